mic_ext_responder: RTL
======================

// Module: mic_ext_responder
// PURPOSE
//  Responder end of the RV32I microcontroller data bus (w_mic_*). Serves every CPU load/store
//  whose address tag addr[31:28] != LOCAL_TAG, drives w_stall/w_data back to the core, and
//  forwards the access as one valid/ready transaction on a downstream peripheral port.
//  Does byte-lane formatting both ways and bounds every access with a timeout.
// PARAMETERS
//  LOCAL_TAG   4'h1          addr[31:28] tag of core-local BRAM; such accesses are ignored
//  TO_BITS     8             width of timeout counter
//  TO_CYCLES   255           downstream cycles without m_ready before forced completion
//  ERR_RDATA   32'hFFFFFFFF  raw read word returned on timeout, before lane extraction
// PORTS
//  CLK          in   1   clock
//  RST          in   1   async reset, active-high
//  w_mic_addr   in   32  CPU byte address
//  w_mic_wdata  in   32  CPU store data, unreplicated
//  w_mic_mmuwe  in   1   CPU external store strobe
//  w_mic_ctrl   in   3   funct3: [1:0] 0=byte 1=half 2=word, [2]=unsigned load
//  w_mic_req    in   2   0=RD 1=WR 2=IF 3=NONE
//  w_stall      out  1   holds the CPU stage
//  w_data       out  32  load result, lane-extracted and extended
//  m_valid      out  1   downstream request
//  m_we         out  1   1=write
//  m_addr       out  32  {addr[31:2],2'b00}
//  m_be         out  4   byte enables
//  m_wdata      out  32  lane-replicated write data
//  m_ready      in   1   downstream accept/complete
//  m_rdata      in   32  downstream read word, valid with m_ready
//  r_err        out  1   sticky timeout flag
//  err_clr      in   1   clears r_err
// BEHAVIOUR
//  - start = !busy & (w_mic_mmuwe | (w_mic_req==0 & w_mic_addr[31:28]!=LOCAL_TAG)).
//    req==2 (IF) and req==3 never start and never stall.
//  - FSM IDLE->BUSY->DONE->IDLE.
//    IDLE: w_stall = start (combinational). On start: latch addr, ctrl, we, wdata;
//      m_valid<=1; go BUSY.
//    BUSY: w_stall=1. m_* held stable while m_valid=1.
//      On m_ready: m_valid<=0, latch m_rdata, go DONE.
//      Else on timeout count==TO_CYCLES: m_valid<=0, latch ERR_RDATA, r_err<=1, go DONE.
//    DONE: w_stall=0 for exactly one cycle; no restart, although the CPU request is still
//      asserted this cycle. Go IDLE.
//  - Minimum stall: 2 cycles (IDLE detect + BUSY with m_ready high on the first m_valid
//    cycle). Timeout stall: TO_CYCLES+2 cycles.
//  - Timeout counter clears on entry to BUSY and increments each BUSY cycle without m_ready.
//  - Write formatting:
//    be: byte = 0001<<a[1:0]; half = 0011<<{a[1],0}; word = 1111.
//    wdata: {4{b}}, {2{h}} or word. Misaligned halfword uses a[1] only; no fault raised.
//  - Read formatting: latched word >> {a[1:0],3'b0}, then sign- or zero-extended per ctrl
//    (000 lb, 100 lbu, 001 lh, 101 lhu, else word).
//  - w_data is registered. It updates on the BUSY->DONE edge and holds until the next read
//    completes, so it is valid through DONE and the following cycle, where the core samples it.
//    Writes leave w_data unchanged.
//  - r_err: set on timeout, cleared by err_clr; set wins when both occur in one cycle.
//  - Reset (async, any state):
//    FSM=IDLE; m_valid=0, m_we=0, m_be=0, m_addr=0, m_wdata=0; w_data=0; r_err=0;
//    counter=0. w_stall forced 0 while RST=1.
//    Reset mid-BUSY drops m_valid without waiting; a late m_ready in IDLE is ignored.
// STRUCTURE
//  - Shared package mic_bus_pkg: ACCESS_READ/WRITE/CODE/NONE, size/funct3 codes, LOCAL_TAG
//    default. Used by the core and this block.
//  - One sub-module mic_lane_fmt (combinational): be/replicate for writes, shift/extend for
//    reads.
//  - Top level holds the FSM, latches, timeout counter and r_err.
// TESTING
//  1 sw 0x2000_0004 = 0xA1B2C3D4, m_ready on first m_valid cycle -> m_we=1, m_be=1111,
//    m_wdata=0xA1B2C3D4, w_stall high exactly 2 cycles.
//  2 sb addr 0x2000_0003, wdata 0x55 -> m_be=1000, m_wdata=0x55555555.
//  3 lb/lbu/lh/lhu at 0x2000_0002, m_rdata=0x80F0_1234 -> w_data 0xFFFFFFF0, 0x000000F0,
//    0xFFFF80F0, 0x000080F0; lw at 0x2000_0000 -> 0x80F01234.
//  4 lw at 0x1000_0000 (local), and req=2 fetch -> no m_valid, w_stall stays 0.
//  5 lw, m_ready never asserted -> completes after TO_CYCLES, w_data=0xFFFFFFFF, r_err=1;
//    err_clr -> r_err=0.
//  6 RST pulsed during BUSY -> m_valid=0 and w_stall=0 at once; stray m_ready afterwards
//    causes no transaction and no w_data change.

Source files
------------

// File: rtl/mic_bus_pkg.sv
// Shared definitions for the RV32I microcontroller data bus (w_mic_*),
// used by the core and by the external responder.
package mic_bus_pkg;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_CODE  = 2'd2,
    ACCESS_NONE  = 2'd3
  } access_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // funct3 load encodings; bit 2 selects zero extension
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] LOCAL_TAG_DEFAULT = 4'h1;

endpackage

// File: rtl/mic_lane_fmt.sv
// Byte-lane formatting between the CPU and the 32-bit peripheral port:
// byte enables and replication for stores, shift and extension for loads.
module mic_lane_fmt
  import mic_bus_pkg::*;
(
  input  logic [1:0]  wr_off_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_off_i,
  input  logic [2:0]  rd_ctrl_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] rd_data_o
);

  logic [31:0] rd_shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_be_o   = 4'b1111;
    wr_data_o = wr_data_i;
    case (wr_size_i)
      SIZE_BYTE: begin
        wr_be_o   = 4'b0001 << wr_off_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      // misaligned halfwords silently use the upper/lower half selected by a[1]
      SIZE_HALF: begin
        wr_be_o   = 4'b0011 << {wr_off_i[1], 1'b0};
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_shifted = rd_word_i >> {rd_off_i, 3'b000};

  always_comb begin
    rd_data_o = rd_shifted;
    case (rd_ctrl_i)
      F3_LB:   rd_data_o = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      F3_LBU:  rd_data_o = {24'd0, rd_shifted[7:0]};
      F3_LH:   rd_data_o = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      F3_LHU:  rd_data_o = {16'd0, rd_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mic_ext_responder.sv
// Responder for CPU loads/stores outside the local BRAM tag: stalls the core,
// forwards one valid/ready transaction downstream and bounds it with a timeout.
module mic_ext_responder
  import mic_bus_pkg::*;
#(
  parameter logic [3:0]  LOCAL_TAG = LOCAL_TAG_DEFAULT,
  parameter int unsigned TO_BITS   = 8,
  parameter int unsigned TO_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_mic_addr,
  input  logic [31:0] w_mic_wdata,
  input  logic        w_mic_mmuwe,
  input  logic [2:0]  w_mic_ctrl,
  input  logic [1:0]  w_mic_req,
  output logic        w_stall,
  output logic [31:0] w_data,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        r_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic               m_valid_q, m_we_q, r_err_q;
  logic [3:0]         m_be_q;
  logic [31:0]        m_addr_q, m_wdata_q, w_data_q;
  logic [1:0]         off_q;
  logic [2:0]         ctrl_q;
  logic [TO_BITS-1:0] cnt_q;

  logic        start, hit_ready, hit_timeout;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_rdata, raw_rdata;

  assign start = (state_q == ST_IDLE) &&
                 (w_mic_mmuwe ||
                  (access_e'(w_mic_req) == ACCESS_READ && w_mic_addr[31:28] != LOCAL_TAG));

  assign hit_ready   = (state_q == ST_BUSY) && m_ready;
  assign hit_timeout = (state_q == ST_BUSY) && !m_ready && (cnt_q == TO_BITS'(TO_CYCLES));
  assign raw_rdata   = m_ready ? m_rdata : ERR_RDATA;

  mic_lane_fmt u_fmt (
    .wr_off_i  (w_mic_addr[1:0]),
    .wr_size_i (w_mic_ctrl[1:0]),
    .wr_data_i (w_mic_wdata),
    .wr_be_o   (fmt_be),
    .wr_data_o (fmt_wdata),
    .rd_off_i  (off_q),
    .rd_ctrl_i (ctrl_q),
    .rd_word_i (raw_rdata),
    .rd_data_o (fmt_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (hit_ready || hit_timeout) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The detect cycle stalls combinationally so the core never advances past the access.
  always_comb begin
    w_stall = 1'b0;
    case (state_q)
      ST_IDLE: w_stall = start;
      ST_BUSY: w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
    if (RST) w_stall = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'd0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      off_q     <= 2'd0;
      ctrl_q    <= 3'd0;
      cnt_q     <= '0;
      w_data_q  <= 32'd0;
      r_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      if (start) begin
        m_valid_q <= 1'b1;
        m_we_q    <= w_mic_mmuwe;
        m_be_q    <= fmt_be;
        m_addr_q  <= {w_mic_addr[31:2], 2'b00};
        m_wdata_q <= fmt_wdata;
        off_q     <= w_mic_addr[1:0];
        ctrl_q    <= w_mic_ctrl;
        cnt_q     <= '0;
      end else if (hit_ready || hit_timeout) begin
        m_valid_q <= 1'b0;
        if (!m_we_q) w_data_q <= fmt_rdata;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (hit_timeout)  r_err_q <= 1'b1;
      else if (err_clr) r_err_q <= 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign w_data  = w_data_q;
  assign r_err   = r_err_q;

endmodule
